// File: rtl/logicnet_lut_layer_pipe_pkg.sv
// Shared definitions for the LogicNet LUT layer: controller states and
// the legal parameter ranges every instance is checked against.
package logicnet_lut_layer_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam int IN_BITS_MIN  = 2;
    localparam int IN_BITS_MAX  = 10;
    localparam int OUT_BITS_MIN = 1;
    localparam int OUT_BITS_MAX = 8;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 64;

    function automatic bit params_legal(input int in_bits, input int out_bits, input int channels);
        return (in_bits >= IN_BITS_MIN) && (in_bits <= IN_BITS_MAX) &&
               (out_bits >= OUT_BITS_MIN) && (out_bits <= OUT_BITS_MAX) &&
               (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX);
    endfunction

endpackage

// File: rtl/logicnet_lut_layer_pipe_table.sv
// One neuron's truth table: single write port, asynchronous read.
// Contents are deliberately not reset so a loaded layer survives rst_n.
module logicnet_lut_table #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IN_BITS-1:0]  waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic [IN_BITS-1:0]  raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);

    logic [OUT_BITS-1:0] mem_q [2**IN_BITS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/logicnet_lut_layer_pipe.sv
// Two-stage LUT layer (S1 = captured addresses, S2 = looked-up results) with
// a RUN/DRAIN/LOAD controller that empties the pipe before tables are rewritten.
module logicnet_lut_layer_pipe
    import logicnet_lut_layer_pipe_pkg::*;
#(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*IN_BITS-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_BITS-1:0] out_data,
    input  logic                         cfg_req,
    output logic                         cfg_ack,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    output logic                         cfg_err,
    output logic [1:0]                   dbg_state_o
);

    if (!params_legal(IN_BITS, OUT_BITS, CHANNELS)) begin : g_param_check
        $error("logicnet_lut_layer_pipe: IN_BITS/OUT_BITS/CHANNELS out of legal range");
    end

    state_e                       state_q;
    logic                         cfg_ack_q;
    logic                         cfg_err_q;
    logic                         s1_valid_q;
    logic                         s2_valid_q;
    logic [CHANNELS*IN_BITS-1:0]  s1_data_q;
    logic [CHANNELS*OUT_BITS-1:0] s2_data_q;
    logic [CHANNELS*OUT_BITS-1:0] lookup;
    logic                         s1_adv;
    logic                         s2_adv;
    logic                         accept;
    logic                         stages_empty;
    logic                         ch_ok;
    logic                         load_we;

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; valid never waits on ready, and the payload is held while stalled.
    assign s2_adv       = !s2_valid_q || out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign in_ready     = rst_n && (state_q == ST_RUN) && !cfg_req && s1_adv;
    assign accept       = in_valid && in_ready;
    assign stages_empty = !s1_valid_q && !s2_valid_q;
    assign ch_ok        = (32'(cfg_ch) < 32'(CHANNELS));
    assign load_we      = cfg_we && ch_ok && (state_q == ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cfg_ack_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cfg_req) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Abandoning the request wins over finishing the drain.
                    if (!cfg_req) begin
                        state_q <= ST_RUN;
                    end else if (stages_empty) begin
                        state_q   <= ST_LOAD;
                        cfg_ack_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!cfg_req) begin
                        state_q   <= ST_RUN;
                        cfg_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    cfg_ack_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= in_data;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= lookup;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else if (cfg_we && !load_we) begin
            cfg_err_q <= 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic ch_we;
        assign ch_we = load_we && (32'(cfg_ch) == c);

        logicnet_lut_table #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_table (
            .clk     (clk),
            .we_i    (ch_we),
            .waddr_i (cfg_addr),
            .wdata_i (cfg_data),
            .raddr_i (s1_data_q[c*IN_BITS +: IN_BITS]),
            .rdata_o (lookup[c*OUT_BITS +: OUT_BITS])
        );
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = s2_data_q;
    assign cfg_ack     = cfg_ack_q;
    assign cfg_err     = cfg_err_q;
    assign dbg_state_o = state_q;

endmodule
